axi_lite_xbar_1ton: RTL

- Parametrised AXI-lite interconnect with one master port (CPU) and N_SLV slave ports (RAM, UART, timer, ...).
- Replaces the point-to-point CPU-to-RAM wiring at top level.
- Decodes addresses by base/mask, routes each read and write transaction to one slave, and answers unmapped addresses itself with DECERR.
- Read and write paths are independent FSMs. Each path has one outstanding transaction.

---
 rtl/axi_lite_xbar_1ton_if.sv | 59 +++++
 rtl/axi_lite_xbar_1ton.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_xbar_1ton_if.sv
// Signal bundle for the 1-to-N AXI-lite crossbar: the CPU-facing m_* port and the
// per-slave s_* vectors. The crossbar uses the slave modport; the environment uses master.
interface axi_lite_xbar_1ton_if #(
  parameter int unsigned N_SLV = 2
) ();
  logic [31:0]         m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [31:0]         m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;
  logic [31:0]         m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [31:0]         m_wdata;
  logic [3:0]          m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;

  logic [31:0]         s_araddr;
  logic [N_SLV-1:0]    s_arvalid;
  logic [N_SLV-1:0]    s_arready;
  logic [N_SLV*32-1:0] s_rdata;
  logic [N_SLV*2-1:0]  s_rresp;
  logic [N_SLV-1:0]    s_rvalid;
  logic [N_SLV-1:0]    s_rready;
  logic [31:0]         s_awaddr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic [N_SLV-1:0]    s_awvalid;
  logic [N_SLV-1:0]    s_awready;
  logic [N_SLV-1:0]    s_wvalid;
  logic [N_SLV-1:0]    s_wready;
  logic [N_SLV*2-1:0]  s_bresp;
  logic [N_SLV-1:0]    s_bvalid;
  logic [N_SLV-1:0]    s_bready;

  modport slave (
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid,
           m_bready,
    output m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_wdata, s_wstrb, s_awvalid, s_wvalid,
           s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );

  modport master (
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid,
           m_bready,
    input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_wdata, s_wstrb, s_awvalid, s_wvalid,
           s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_lite_xbar_1ton.sv
// AXI-lite 1-to-N crossbar: base/mask decode, one outstanding read and one outstanding
// write, independent FSMs; unmapped accesses are answered locally with DECERR.
module axi_lite_xbar_1ton #(
  parameter int unsigned        N_SLV       = 2,
  parameter logic [N_SLV*32-1:0] SLV_BASE   = {32'h8000_0000, 32'h1000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK   = {32'hF800_0000, 32'hFFFF_F000},
  parameter logic [31:0]        DECERR_DATA = 32'hDEAD_BEEF
) (
  input logic                   clk,
  input logic                   rst,
  axi_lite_xbar_1ton_if.slave   bus
);
  localparam int unsigned IdxW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WFwd, WResp} w_state_e;

  logic [IdxW-1:0] ar_idx, aw_idx;
  logic            ar_hit, aw_hit;
  logic [31:0]     s_rdata_a [N_SLV];
  logic [1:0]      s_rresp_a [N_SLV];
  logic [1:0]      s_bresp_a [N_SLV];

  // Iterate downwards so the lowest matching index is the one that sticks.
  always_comb begin
    ar_hit = 1'b0;
    ar_idx = '0;
    aw_hit = 1'b0;
    aw_idx = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((bus.m_araddr & SLV_MASK[32*i+:32]) == SLV_BASE[32*i+:32]) begin
        ar_hit = 1'b1;
        ar_idx = IdxW'(i);
      end
      if ((bus.m_awaddr & SLV_MASK[32*i+:32]) == SLV_BASE[32*i+:32]) begin
        aw_hit = 1'b1;
        aw_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_SLV); i++) begin
      s_rdata_a[i] = bus.s_rdata[32*i+:32];
      s_rresp_a[i] = bus.s_rresp[2*i+:2];
      s_bresp_a[i] = bus.s_bresp[2*i+:2];
    end
  end

  // ---------------- read path ----------------
  r_state_e        r_state_q, r_state_d;
  logic [IdxW-1:0] r_tgt_q, r_tgt_d;
  logic            r_unmap_q, r_unmap_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rvalid_q, rvalid_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= RIdle;
      r_tgt_q   <= '0;
      r_unmap_q <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_tgt_q   <= r_tgt_d;
      r_unmap_q <= r_unmap_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    r_state_d     = r_state_q;
    r_tgt_d       = r_tgt_q;
    r_unmap_d     = r_unmap_q;
    araddr_d      = araddr_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rvalid_d      = rvalid_q;
    bus.m_arready = 1'b0;
    bus.s_arvalid = '0;
    bus.s_rready  = '0;
    bus.m_rvalid  = rvalid_q;
    bus.m_rdata   = rdata_q;
    bus.m_rresp   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        bus.m_arready = 1'b1;
        if (bus.m_arvalid) begin
          araddr_d  = bus.m_araddr;
          r_tgt_d   = ar_idx;
          r_unmap_d = !ar_hit;
          if (ar_hit) begin
            r_state_d = RAddr;
          end else begin
            rdata_d   = DECERR_DATA;
            rresp_d   = 2'b11;
            rvalid_d  = 1'b1;
            r_state_d = RData;
          end
        end
      end
      RAddr: begin
        bus.s_arvalid[r_tgt_q] = 1'b1;
        if (bus.s_arready[r_tgt_q]) r_state_d = RData;
      end
      RData: begin
        if (r_unmap_q) begin
          if (bus.m_rready) begin
            rvalid_d  = 1'b0;
            r_state_d = RIdle;
          end
        end else begin
          bus.m_rvalid          = bus.s_rvalid[r_tgt_q];
          bus.m_rdata           = s_rdata_a[r_tgt_q];
          bus.m_rresp           = s_rresp_a[r_tgt_q];
          bus.s_rready[r_tgt_q] = bus.m_rready;
          if (bus.s_rvalid[r_tgt_q] && bus.m_rready) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign bus.s_araddr = araddr_q;

  // ---------------- write path ----------------
  w_state_e        w_state_q, w_state_d;
  logic [IdxW-1:0] w_tgt_q, w_tgt_d;
  logic            w_unmap_q, w_unmap_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic            aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            aw_fire, w_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= WIdle;
      w_tgt_q   <= '0;
      w_unmap_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_tgt_q   <= w_tgt_d;
      w_unmap_q <= w_unmap_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    w_state_d     = w_state_q;
    w_tgt_d       = w_tgt_q;
    w_unmap_d     = w_unmap_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    aw_pend_d     = aw_pend_q;
    w_pend_d      = w_pend_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    aw_fire       = 1'b0;
    w_fire        = 1'b0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.s_awvalid = '0;
    bus.s_wvalid  = '0;
    bus.s_bready  = '0;
    bus.m_bvalid  = bvalid_q;
    bus.m_bresp   = bresp_q;
    unique case (w_state_q)
      WIdle: begin
        bus.m_awready = !aw_held_q;
        bus.m_wready  = !w_held_q;
        aw_fire       = !aw_held_q && bus.m_awvalid;
        w_fire        = !w_held_q && bus.m_wvalid;
        if (aw_fire) begin
          awaddr_d  = bus.m_awaddr;
          w_tgt_d   = aw_idx;
          w_unmap_d = !aw_hit;
          aw_held_d = 1'b1;
        end
        if (w_fire) begin
          wdata_d  = bus.m_wdata;
          wstrb_d  = bus.m_wstrb;
          w_held_d = 1'b1;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (w_unmap_d) begin
            bvalid_d  = 1'b1;
            bresp_d   = 2'b11;
            w_state_d = WResp;
          end else begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            w_state_d = WFwd;
          end
        end
      end
      WFwd: begin
        bus.s_awvalid[w_tgt_q] = aw_pend_q;
        bus.s_wvalid[w_tgt_q]  = w_pend_q;
        if (bus.s_awready[w_tgt_q]) aw_pend_d = 1'b0;
        if (bus.s_wready[w_tgt_q])  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) w_state_d = WResp;
      end
      WResp: begin
        if (w_unmap_q) begin
          if (bus.m_bready) begin
            bvalid_d  = 1'b0;
            w_state_d = WIdle;
          end
        end else begin
          bus.m_bvalid          = bus.s_bvalid[w_tgt_q];
          bus.m_bresp           = s_bresp_a[w_tgt_q];
          bus.s_bready[w_tgt_q] = bus.m_bready;
          if (bus.s_bvalid[w_tgt_q] && bus.m_bready) w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign bus.s_awaddr = awaddr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_wstrb  = wstrb_q;
endmodule
